// File: rtl/pulse_stretch_pkg.sv
// Shared types for the LED pulse stretcher.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_stretch_edge_detect.sv
// Rising-edge detector with a configurable reset value for the history flop.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sig_q <= RESET_VAL;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into visible ON/GAP LED pulses, queueing extras.
//
// state | meaning
// IDLE  | nothing to show, waiting for an event
// ON    | LED lit, counting 2^N cycles
// GAP   | LED dark, counting 2^N cycles before the next pulse may start
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int N = 11,
  parameter int Q = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         event_in,
  input  logic         clear_dropped,
  output logic         led_out,
  output logic         busy,
  output logic [Q-1:0] pending,
  output logic         dropped
);

  localparam logic [Q-1:0] PEND_MAX = {Q{1'b1}};
  localparam logic [N-1:0] CNT_LAST = {N{1'b1}};

  state_t         state;
  logic [N-1:0]   cnt;
  logic           evt_edge;
  logic           phase_end;
  logic           gap_end;
  logic           ev_queue;
  logic           drop_set;

  // History flop resets high so a level held through reset release is ignored.
  edge_detect #(.RESET_VAL(1'b1)) u_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (event_in),
    .rise  (evt_edge)
  );

  assign phase_end = (cnt == CNT_LAST);
  assign gap_end   = (state == GAP) && phase_end;
  assign ev_queue  = evt_edge && (state != IDLE) && !gap_end;
  assign drop_set  = ev_queue && (pending == PEND_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      led_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (evt_edge) begin
            state   <= ON;
            cnt     <= '0;
            led_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ON: begin
          if (phase_end) begin
            state   <= GAP;
            cnt     <= '0;
            led_out <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            cnt <= '0;
            if ((pending != '0) || evt_edge) begin
              state   <= ON;
              led_out <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          led_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // An edge landing exactly at GAP-end is consumed directly, so the queue holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else if (ev_queue) begin
      if (pending != PEND_MAX) pending <= pending + 1'b1;
    end else if (gap_end && (pending != '0) && !evt_edge) begin
      pending <= pending - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             dropped <= 1'b0;
    else if (drop_set)      dropped <= 1'b1;
    else if (clear_dropped) dropped <= 1'b0;
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with N=3 (8-cycle phases) and Q=2.
module tb_pulse_stretch;

  logic       clk;
  logic       reset;
  logic       event_in;
  logic       clear_dropped;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       dropped;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic       led_log  [0:127];
  logic       busy_log [0:127];
  logic [1:0] pend_log [0:127];
  logic       drop_log [0:127];

  logic [127:0] ev;
  logic [127:0] clr;

  pulse_stretch #(.N(3), .Q(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .event_in      (event_in),
    .clear_dropped (clear_dropped),
    .led_out       (led_out),
    .busy          (busy),
    .pending       (pending),
    .dropped       (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bit per cycle and log outputs 1 time unit after each edge.
  task automatic run_seq(input logic [127:0] e, input logic [127:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      event_in      = e[i];
      clear_dropped = c[i];
      tick();
      led_log[i]  = led_out;
      busy_log[i] = busy;
      pend_log[i] = pending;
      drop_log[i] = dropped;
    end
    event_in      = 1'b0;
    clear_dropped = 1'b0;
  endtask

  function automatic int count_rises(input int n);
    int   r = 0;
    logic prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (led_log[i] && !prev) r++;
      prev = led_log[i];
    end
    return r;
  endfunction

  function automatic int count_high(input int n, input bit use_busy);
    int h = 0;
    for (int i = 0; i < n; i++)
      if (use_busy ? busy_log[i] : led_log[i]) h++;
    return h;
  endfunction

  initial begin
    reset         = 1'b0;
    event_in      = 1'b0;
    clear_dropped = 1'b0;
    repeat (3) tick();
    check("rst_led", led_out, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_dropped", dropped, 0);
    reset = 1'b1;
    repeat (2) tick();

    // single pulse
    ev = '0; ev[0] = 1'b1; clr = '0;
    run_seq(ev, clr, 24);
    check("single_led_first", led_log[0], 1);
    check("single_led_cycles", count_high(24, 0), 8);
    check("single_led_off_at8", led_log[8], 0);
    check("single_busy_cycles", count_high(24, 1), 16);
    check("single_busy_end", busy_log[16], 0);
    check("single_pend", pend_log[3], 0);

    // burst of 5 events in the first ON phase
    ev = '0; ev[0] = 1; ev[2] = 1; ev[4] = 1; ev[6] = 1; ev[8] = 1;
    run_seq(ev, clr, 80);
    check("burst_pend_sat", pend_log[6], 3);
    check("burst_pend_held", pend_log[8], 3);
    check("burst_dropped", drop_log[8], 1);
    check("burst_pulses", count_rises(80), 4);
    check("burst_led_cycles", count_high(80, 0), 32);
    check("burst_pend_ge1", pend_log[16], 2);
    check("burst_pend_ge2", pend_log[32], 1);
    check("burst_pend_ge3", pend_log[48], 0);
    check("burst_busy_last", busy_log[63], 1);
    check("burst_idle", busy_log[64], 0);
    clr = '0; clr[0] = 1'b1; ev = '0;
    run_seq(ev, clr, 2);
    check("burst_clear", drop_log[0], 0);

    // event exactly at GAP-end with pending=1
    clr = '0;
    ev = '0; ev[0] = 1; ev[2] = 1; ev[16] = 1;
    run_seq(ev, clr, 56);
    check("gapend_p1_pend_before", pend_log[15], 1);
    check("gapend_p1_pend", pend_log[16], 1);
    check("gapend_p1_led", led_log[16], 1);
    check("gapend_p1_pulses", count_rises(56), 3);
    check("gapend_p1_busy", count_high(48, 1), 48);
    check("gapend_p1_idle", busy_log[48], 0);

    // event exactly at GAP-end with pending=0
    ev = '0; ev[0] = 1; ev[16] = 1;
    run_seq(ev, clr, 40);
    check("gapend_p0_led", led_log[16], 1);
    check("gapend_p0_pend", pend_log[16], 0);
    check("gapend_p0_busy", count_high(32, 1), 32);
    check("gapend_p0_idle", busy_log[32], 0);

    // level held high 40 cycles
    ev = '0;
    for (int i = 0; i < 40; i++) ev[i] = 1'b1;
    run_seq(ev, clr, 60);
    check("level_pulses", count_rises(60), 1);
    check("level_led_cycles", count_high(60, 0), 8);

    // level held across reset release
    event_in = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ev = '1;
    run_seq(ev, clr, 20);
    check("rel_pulses", count_rises(20), 0);
    check("rel_busy", count_high(20, 1), 0);
    ev = '0;
    run_seq(ev, clr, 2);

    // reset mid-ON with pending=2
    ev = '0; ev[0] = 1; ev[2] = 1; ev[4] = 1;
    run_seq(ev, clr, 6);
    check("midrst_pend_pre", pend_log[5], 2);
    check("midrst_led_pre", led_log[5], 1);
    reset = 1'b0;
    #1;
    check("midrst_led", led_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pend", pending, 0);
    tick();
    reset = 1'b1;
    ev = '0;
    run_seq(ev, clr, 20);
    check("midrst_no_pulse", count_rises(20), 0);
    ev = '0; ev[0] = 1;
    run_seq(ev, clr, 20);
    check("midrst_new_edge", led_log[0], 1);

    // sticky flag: set beats clear, clear next cycle wins
    ev = '0; ev[0] = 1; ev[2] = 1; ev[4] = 1; ev[6] = 1; ev[8] = 1;
    clr = '0; clr[8] = 1; clr[9] = 1;
    run_seq(ev, clr, 80);
    check("sticky_pre", drop_log[7], 0);
    check("sticky_set_wins", drop_log[8], 1);
    check("sticky_cleared", drop_log[9], 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Output-side counterpart to the button debouncer. The debouncer turns slow, noisy human-timescale input into clean clock-domain signals. This block turns single-cycle clock-domain events into LED pulses a human can see. Each rising edge on `event_in` produces one fixed-length ON period followed by a fixed-length OFF gap, so back-to-back events stay distinguishable. Events arriving while a pulse is in progress are queued in a saturating counter. It sits between internal logic (or a debouncer output) and board LEDs.

## Interface
- `N`, 11, phase counter width; ON phase = OFF gap = 2^N cycles each
- `Q`, 3, pending-event counter width; saturates at 2^Q−1
- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `event_in`  in  1  synchronous to `clk`; each 0→1 transition is one event
- `clear_dropped`  in  1  synchronous; clears `dropped` when high
- `led_out`  out  1  high during ON phase; registered, glitch-free
- `busy`  out  1  high whenever state ≠ IDLE
- `pending`  out  Q  queued events not yet displayed
- `dropped`  out  1  sticky; set when an event arrives with `pending` saturated

## Operation
- Edge detect: `event_q` registers `event_in`; `edge = event_in & ~event_q`.
- `event_q` resets to 1, so a level held high through reset release is not an event.
- Level held high produces exactly one event.
- FSM states are IDLE, ON and GAP. The phase counter `cnt` is N bits and is zeroed on every state entry.
- IDLE:
  - `edge` → ON; `pending` unchanged (event consumed directly).
- ON:
  - `led_out`=1; `cnt` increments each cycle.
  - At `cnt`=2^N−1 → GAP.
- GAP:
  - `led_out`=0; `cnt` increments.
  - At `cnt`=2^N−1: if `pending`>0 or `edge` → ON, otherwise → IDLE.
- Pending update (every cycle, in this priority):
  - `edge` while in ON/GAP, not at GAP-end: `pending`+1 if below max. If at max, `pending` is unchanged and `dropped` is set.
  - GAP-end with `pending`>0, no `edge`: `pending`−1.
  - GAP-end with `pending`>0 and `edge`: `pending` unchanged (one in, one out).
  - GAP-end with `pending`=0 and `edge`: → ON, `pending` stays 0.
- `dropped`:
  - Set has priority over `clear_dropped` in the same cycle.
  - `clear_dropped` otherwise forces it to 0.
- Arithmetic: `cnt` wraps naturally but is always reset on transition. `pending` never wraps in either direction.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0, `event_q`=1.
  - `led_out`=0, `busy`=0, `pending`=0, `dropped`=0.
- Latency:
  - `event_in` first sampled high at edge k → `led_out`=1 and `busy`=1 after edge k.
  - `led_out` stays high exactly 2^N cycles, then low for at least 2^N cycles.
- Minimum event-to-event display period: 2^(N+1) cycles.
- `busy` falls one cycle after GAP-end when nothing is pending.
- Outputs are decoded from registered state and counters only. No combinational path from `event_in` to any output.
- Reset assertion mid-ON or mid-GAP drops `led_out` asynchronously and discards the queue.

## Structure
- `pulse_stretch_pkg`: `state_t` enum (IDLE, ON, GAP).
- Sub-module `edge_detect`: rising-edge detector with parameterisable reset value of the history flop. Reusable by other input-side blocks.
- Top module holds the FSM, phase counter, pending counter and sticky flag.

## Test plan
All tests use N=3 (8-cycle phases) and Q=2 (max pending 3).
- **Single pulse:** single 1-cycle `event_in` pulse → `led_out` high 8 cycles starting the cycle after sampling, low 8 cycles; `busy` high 16 cycles then 0; `pending` stays 0.
- **Burst with overflow:** 5 events during the first ON phase → `pending` reaches 3 and saturates; `dropped`=1; 4 total LED pulses, each 8 on / 8 off; `pending` 3→2→1→0 at successive GAP-ends.
- **Simultaneous GAP-end event:** event exactly at GAP-end with `pending`=1 → `pending` stays 1, next ON starts immediately. Event at GAP-end with `pending`=0 → ON re-entered, `busy` never drops.
- **Level and reset-release:** `event_in` held high 40 cycles → exactly one pulse. `event_in` high across reset release → no pulse.
- **Reset mid-operation:** `reset` low mid-ON with `pending`=2 → outputs 0 immediately. After release, no pulse until a new edge.
- **Sticky flag priority:** `clear_dropped` asserted the same cycle as an overflow event → `dropped` stays 1. Asserted one cycle later → `dropped`=0.
